adc_sd_nano: RTL and testbench

ADC_SD_NANO -- requirements
Module: adc_sd_nano

---
 rtl/adc_sd_nano_if.sv | 23 ++
 rtl/adc_sd_nano.sv | 110 +++++++++++
 tb/tb_adc_sd_nano.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/adc_sd_nano_if.sv
// Sample output handshake between the sigma-delta converter and its consumer.
interface adc_sd_nano_if #(
  parameter int OUT_W = 16
);
  logic [OUT_W-1:0] ADCout;
  logic             ADCvalid;
  logic             ADCready;
  logic             Overrun;

  modport master (
    output ADCout,
    output ADCvalid,
    output Overrun,
    input  ADCready
  );

  modport slave (
    input  ADCout,
    input  ADCvalid,
    input  Overrun,
    output ADCready
  );
endinterface

// File: rtl/adc_sd_nano.sv
// First-order sigma-delta ADC front end: synchronised comparator feedback,
// boxcar decimation over 2^DECIM_LOG2 clocks, excess-2^15 output samples.
module adc_sd_nano #(
  parameter int DECIM_LOG2 = 8,
  parameter int OUT_W      = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Enable,
  input  logic          CompIn,
  output logic          FbOut,
  adc_sd_nano_if.master adc
);

  localparam int SH = OUT_W - DECIM_LOG2;
  localparam logic [OUT_W-1:0] MID_CODE = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t state, state_nx;

  logic                  comp_m;
  logic                  comp_s;
  logic [DECIM_LOG2-1:0] win_cnt;
  logic [DECIM_LOG2:0]   acc;
  logic [DECIM_LOG2:0]   acc_sum;
  logic [OUT_W-1:0]      scaled;
  logic                  active;
  logic                  win_wrap;
  logic                  win_end_run;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: Enable low returns to IDLE from anywhere.
  always_comb begin
    state_nx = state;
    if (!Enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nx = SETTLE;
        SETTLE:  if (win_wrap) state_nx = RUN;
        RUN:     state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM-derived controls: window end is the counter wrap cycle.
  always_comb begin
    active      = (state != IDLE);
    win_wrap    = active && (win_cnt == '1);
    win_end_run = (state == RUN) && win_wrap;
  end

  // Two-flop synchroniser on the comparator, then registered feedback.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      comp_m <= 1'b0;
      comp_s <= 1'b0;
      FbOut  <= 1'b0;
    end else begin
      comp_m <= CompIn;
      comp_s <= comp_m;
      FbOut  <= active ? comp_s : 1'b0;
    end
  end

  // Window counter: held at zero in IDLE, so SETTLE entry starts at zero and
  // the wrap itself provides the clear on RUN entry.
  always_ff @(posedge Clk) begin
    if (Reset || !active) win_cnt <= '0;
    else                  win_cnt <= win_cnt + DECIM_LOG2'(1);
  end

  // Ones count including the current cycle, and its scaled output code.
  always_comb begin
    acc_sum = acc + (DECIM_LOG2+1)'(comp_s);
    if (acc_sum[DECIM_LOG2]) scaled = '1;
    else                     scaled = OUT_W'(acc_sum[DECIM_LOG2-1:0]) << SH;
  end

  // Accumulator: the window-end cycle's comp_s is folded into the sample via
  // acc_sum, so clearing here makes the next window start from its own
  // first comp_s; SETTLE and IDLE keep it at zero.
  always_ff @(posedge Clk) begin
    if (Reset || state != RUN || win_wrap) acc <= '0;
    else                                   acc <= acc_sum;
  end

  // Output sample, valid handshake and sticky overrun.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      adc.ADCout   <= MID_CODE;
      adc.ADCvalid <= 1'b0;
      adc.Overrun  <= 1'b0;
    end else if (win_end_run) begin
      adc.ADCout   <= scaled;
      adc.ADCvalid <= 1'b1;
      if (adc.ADCvalid && !adc.ADCready) adc.Overrun <= 1'b1;
    end else if (adc.ADCvalid && adc.ADCready) begin
      adc.ADCvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sd_nano.sv
// Directed bench for adc_sd_nano with a cycle-level reference model based on
// time-since-enable arithmetic and per-window ones counts.
module tb_adc_sd_nano;

  localparam int D = 8;
  localparam int N = 1 << D;

  logic clk = 1'b0;
  logic rst, en, cin, ready, tog;
  logic fb;

  int vectors = 0;
  int miscmp  = 0;

  adc_sd_nano_if #(.OUT_W(16)) bus ();
  assign bus.ADCready = ready;

  adc_sd_nano #(.DECIM_LOG2(D), .OUT_W(16)) dut (
    .Clk    (clk),
    .Reset  (rst),
    .Enable (en),
    .CompIn (cin),
    .FbOut  (fb),
    .adc    (bus.master)
  );

  always #5 clk = ~clk;

  // Reference model
  int          age = -1;       // cycles since SETTLE entry, -1 when idle
  int          sum = 0;        // ones in current RUN window
  logic        ch0 = 0, ch1 = 0;
  logic        m_fb = 0, m_val = 0, m_ovr = 0;
  logic [15:0] m_out = 16'h8000;
  logic        started = 0;

  always @(posedge clk) begin
    logic cs;
    if (rst) begin
      age = -1; sum = 0; ch0 = 0; ch1 = 0;
      m_fb = 0; m_val = 0; m_ovr = 0; m_out = 16'h8000;
      started = 1;
    end else begin
      cs  = ch1;
      ch1 = ch0;
      ch0 = cin;
      m_fb = (age >= 0) ? cs : 1'b0;
      if (age >= N) sum += cs;
      if (age >= N && (age % N) == N - 1) begin
        if (m_val && !ready) m_ovr = 1;
        m_out = (sum == N) ? 16'hFFFF : 16'(sum * (65536 / N));
        m_val = 1;
        sum = 0;
      end else if (m_val && ready) begin
        m_val = 0;
      end
      if (!en)          age = -1;
      else if (age < 0) begin age = 0; sum = 0; end
      else              age = age + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("FbOut",    32'(fb),           32'(m_fb));
      check("ADCout",   32'(bus.ADCout),   32'(m_out));
      check("ADCvalid", 32'(bus.ADCvalid), 32'(m_val));
      check("Overrun",  32'(bus.Overrun),  32'(m_ovr));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (tog) cin = ~cin;
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.ADCvalid && n < limit);
    if (!bus.ADCvalid) begin
      vectors++;
      miscmp++;
      $display("FAIL wait_valid: no ADCvalid within %0d cycles", limit);
    end
  endtask

  initial begin
    int n;
    rst = 1; en = 0; cin = 0; ready = 0; tog = 0;
    step(3);
    check("rst_out",   32'(bus.ADCout),   32'h8000);
    check("rst_valid", 32'(bus.ADCvalid), 32'h0);
    check("rst_ovr",   32'(bus.Overrun),  32'h0);
    check("rst_fb",    32'(fb),           32'h0);
    rst = 0;
    step(2);

    // All ones
    cin = 1; ready = 1; en = 1;
    wait_valid(2 * N + 50, n);
    check("ones_latency", 32'(n - 1), 32'd512);
    check("ones_out",     32'(bus.ADCout), 32'hFFFF);
    step(1);
    check("ones_consumed", 32'(bus.ADCvalid), 32'h0);
    en = 0;
    step(4);

    // All zeros
    cin = 0;
    step(3);
    en = 1;
    wait_valid(2 * N + 50, n);
    check("zeros_out", 32'(bus.ADCout), 32'h0000);
    en = 0;
    step(4);

    // Alternating comparator
    tog = 1; en = 1;
    wait_valid(2 * N + 50, n);
    check("toggle_out", 32'(bus.ADCout), 32'h8000);
    tog = 0; en = 0;
    step(4);

    // Overrun across two window ends
    ready = 0; cin = 1; en = 1;
    wait_valid(2 * N + 50, n);
    check("ovr_first_out", 32'(bus.ADCout), 32'hFFFF);
    check("ovr_first_flag", 32'(bus.Overrun), 32'h0);
    cin = 0;
    step(N);
    check("ovr_second_out",   32'(bus.ADCout),   32'h0200);
    check("ovr_second_valid", 32'(bus.ADCvalid), 32'h1);
    check("ovr_second_flag",  32'(bus.Overrun),  32'h1);
    ready = 1;
    step(1);
    ready = 0;
    check("ovr_consumed_valid", 32'(bus.ADCvalid), 32'h0);
    check("ovr_sticky",         32'(bus.Overrun),  32'h1);
    en = 0;
    step(4);

    // Enable drop at RUN cycle 300; pending sample kept
    cin = 1; ready = 0; en = 1;
    wait_valid(2 * N + 50, n);
    step(43);
    en = 0; cin = 0;
    step(20);
    check("drop_pending_valid", 32'(bus.ADCvalid), 32'h1);
    check("drop_pending_out",   32'(bus.ADCout),   32'hFFFF);
    ready = 1;
    step(1);
    ready = 0;
    check("drop_consumed", 32'(bus.ADCvalid), 32'h0);
    en = 1;
    wait_valid(2 * N + 50, n);
    check("reenable_latency", 32'(n - 1), 32'd512);
    check("reenable_out",     32'(bus.ADCout), 32'h0000);
    en = 0;
    step(4);

    // Reset mid-RUN with ADCready high
    cin = 1; ready = 0; en = 1;
    step(600);
    rst = 1; ready = 1;
    step(1);
    check("midrst_out",   32'(bus.ADCout),   32'h8000);
    check("midrst_valid", 32'(bus.ADCvalid), 32'h0);
    check("midrst_ovr",   32'(bus.Overrun),  32'h0);
    check("midrst_fb",    32'(fb),           32'h0);
    rst = 0;
    wait_valid(2 * N + 50, n);
    check("postrst_latency", 32'(n - 1), 32'd512);
    check("postrst_out",     32'(bus.ADCout), 32'hFFFF);
    en = 0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
